// File: rtl/timing_ir_unit.sv
// Instruction-cycle counter and instruction register with RESET/NMI/IRQ
// opcode injection at opcode-load edges.
module timing_ir_unit (
    input  logic       clk_ph2,
    input  logic       rst,
    input  logic       I_cycle,
    input  logic       R_cycle,
    input  logic [7:0] data_in,
    input  logic       rdy,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       irq_mask,
    output logic [2:0] cycle,
    output logic [7:0] IR,
    output logic       sync,
    output logic [1:0] int_src,
    output logic       pc_inc_inhibit,
    output logic       cycle_err
);

    localparam logic [1:0] SRC_OPC   = 2'b00;
    localparam logic [1:0] SRC_IRQ   = 2'b01;
    localparam logic [1:0] SRC_NMI   = 2'b10;
    localparam logic [1:0] SRC_RESET = 2'b11;
    localparam logic [7:0] OP_BRK    = 8'h00;
    localparam logic [2:0] CYCLE_MAX = 3'd7;

    logic [2:0] cycle_q, cycle_d;
    logic [7:0] ir_q, ir_d;
    logic       sync_q, sync_d;
    logic [1:0] int_src_q, int_src_d;
    logic       cycle_err_q, cycle_err_d;
    logic       reset_pend_q, reset_pend_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_s1_q, nmi_s1_d;
    logic       nmi_s2_q, nmi_s2_d;
    logic       irq_pend_q, irq_pend_d;
    logic       nmi_fall_s;
    logic       nmi_take_s;

    // Next-state logic: counter, opcode load/injection, interrupt sampling.
    always_comb begin
        cycle_d      = cycle_q;
        ir_d         = ir_q;
        sync_d       = sync_q;
        int_src_d    = int_src_q;
        cycle_err_d  = cycle_err_q;
        reset_pend_d = reset_pend_q;
        nmi_take_s   = 1'b0;
        // Sampling keeps running during stalls so no NMI edge is lost.
        nmi_s1_d     = nmi_n;
        nmi_s2_d     = nmi_s1_q;
        irq_pend_d   = ~irq_n & ~irq_mask;
        nmi_fall_s   = nmi_s2_q & ~nmi_s1_q;

        if (rdy) begin
            sync_d = R_cycle;
            if (R_cycle) begin
                cycle_d = 3'd0;
                if (reset_pend_q) begin
                    ir_d         = OP_BRK;
                    int_src_d    = SRC_RESET;
                    reset_pend_d = 1'b0;
                end else if (nmi_pend_q) begin
                    ir_d       = OP_BRK;
                    int_src_d  = SRC_NMI;
                    nmi_take_s = 1'b1;
                end else if (irq_pend_q) begin
                    ir_d      = OP_BRK;
                    int_src_d = SRC_IRQ;
                end else begin
                    ir_d      = data_in;
                    int_src_d = SRC_OPC;
                end
            end else if (I_cycle) begin
                // Saturate rather than wrap so the decoder never sees a bogus cycle 0.
                if (cycle_q == CYCLE_MAX) begin
                    cycle_err_d = 1'b1;
                end else begin
                    cycle_d = cycle_q + 3'd1;
                end
            end else begin
                cycle_d = cycle_q;
            end
        end else begin
            sync_d = sync_q;
        end

        nmi_pend_d = nmi_fall_s | (nmi_pend_q & ~nmi_take_s);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_ph2) begin
        if (!rst) begin
            cycle_q      <= 3'd0;
            ir_q         <= OP_BRK;
            sync_q       <= 1'b0;
            int_src_q    <= SRC_RESET;
            cycle_err_q  <= 1'b0;
            reset_pend_q <= 1'b1;
            nmi_pend_q   <= 1'b0;
            nmi_s1_q     <= 1'b1;
            nmi_s2_q     <= 1'b1;
            irq_pend_q   <= 1'b0;
        end else begin
            cycle_q      <= cycle_d;
            ir_q         <= ir_d;
            sync_q       <= sync_d;
            int_src_q    <= int_src_d;
            cycle_err_q  <= cycle_err_d;
            reset_pend_q <= reset_pend_d;
            nmi_pend_q   <= nmi_pend_d;
            nmi_s1_q     <= nmi_s1_d;
            nmi_s2_q     <= nmi_s2_d;
            irq_pend_q   <= irq_pend_d;
        end
    end

    assign cycle          = cycle_q;
    assign IR             = ir_q;
    assign sync           = sync_q;
    assign int_src        = int_src_q;
    assign cycle_err      = cycle_err_q;
    assign pc_inc_inhibit = (int_src_q != SRC_OPC);

endmodule

// File: tb/tb_timing_ir_unit.sv
// Vector-driven bench for timing_ir_unit; expected outputs are queued as each
// vector is driven and checked one clock later.
module tb_timing_ir_unit;

    logic       clk_ph2 = 1'b0;
    logic       rst = 1'b0;
    logic       I_cycle = 1'b0;
    logic       R_cycle = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rdy = 1'b1;
    logic       nmi_n = 1'b1;
    logic       irq_n = 1'b1;
    logic       irq_mask = 1'b1;
    logic [2:0] cycle;
    logic [7:0] IR;
    logic       sync;
    logic [1:0] int_src;
    logic       pc_inc_inhibit;
    logic       cycle_err;

    timing_ir_unit dut (
        .clk_ph2(clk_ph2), .rst(rst), .I_cycle(I_cycle), .R_cycle(R_cycle),
        .data_in(data_in), .rdy(rdy), .nmi_n(nmi_n), .irq_n(irq_n),
        .irq_mask(irq_mask), .cycle(cycle), .IR(IR), .sync(sync),
        .int_src(int_src), .pc_inc_inhibit(pc_inc_inhibit), .cycle_err(cycle_err)
    );

    always #5 clk_ph2 = ~clk_ph2;

    // ctl bits: {rst, rdy, R_cycle, I_cycle, nmi_n, irq_n, irq_mask}
    typedef struct {
        logic [6:0] ctl;
        logic [7:0] din;
        logic [2:0] cyc;
        logic [7:0] ir;
        logic       snc;
        logic [1:0] src;
        logic       err;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic [6:0] ctl, input logic [7:0] din,
                                input logic [2:0] cyc, input logic [7:0] ir,
                                input logic snc, input logic [1:0] src, input logic err);
        vec_t v;
        v.ctl = ctl; v.din = din; v.cyc = cyc; v.ir = ir;
        v.snc = snc; v.src = src; v.err = err;
        return v;
    endfunction

    task automatic run(input vec_t v, input string name);
        vec_t e;
        logic exp_inh;
        @(negedge clk_ph2);
        {rst, rdy, R_cycle, I_cycle, nmi_n, irq_n, irq_mask} = v.ctl;
        data_in = v.din;
        exp_q.push_back(v);
        @(posedge clk_ph2);
        #1;
        e = exp_q.pop_front();
        exp_inh = (e.src != 2'b00);
        tests++;
        if (cycle !== e.cyc || IR !== e.ir || sync !== e.snc || int_src !== e.src ||
            cycle_err !== e.err || pc_inc_inhibit !== exp_inh) begin
            fails++;
            $display("FAIL %s: got cyc=%0d ir=%h sync=%b src=%b err=%b inh=%b, want cyc=%0d ir=%h sync=%b src=%b err=%b inh=%b",
                     name, cycle, IR, sync, int_src, cycle_err, pc_inc_inhibit,
                     e.cyc, e.ir, e.snc, e.src, e.err, exp_inh);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, RESET injection, then a normal fetch
        tbl.push_back(mk(7'b0100111, 8'h00, 3'd0, 8'h00, 1'b0, 2'd3, 1'b0));
        tbl.push_back(mk(7'b0100111, 8'h00, 3'd0, 8'h00, 1'b0, 2'd3, 1'b0));
        tbl.push_back(mk(7'b1100111, 8'h00, 3'd0, 8'h00, 1'b0, 2'd3, 1'b0));
        tbl.push_back(mk(7'b1110111, 8'h69, 3'd0, 8'h00, 1'b1, 2'd3, 1'b0));
        tbl.push_back(mk(7'b1100111, 8'h69, 3'd0, 8'h00, 1'b0, 2'd3, 1'b0));
        tbl.push_back(mk(7'b1110111, 8'h69, 3'd0, 8'h69, 1'b1, 2'd0, 1'b0));
        tbl.push_back(mk(7'b1100111, 8'h69, 3'd0, 8'h69, 1'b0, 2'd0, 1'b0));
        // Counter sequence and R_cycle priority over I_cycle
        tbl.push_back(mk(7'b1101111, 8'h00, 3'd1, 8'h69, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(7'b1101111, 8'h00, 3'd2, 8'h69, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(7'b1110111, 8'hA9, 3'd0, 8'hA9, 1'b1, 2'd0, 1'b0));
        tbl.push_back(mk(7'b1111111, 8'h4C, 3'd0, 8'h4C, 1'b1, 2'd0, 1'b0));
        tbl.push_back(mk(7'b1100111, 8'h00, 3'd0, 8'h4C, 1'b0, 2'd0, 1'b0));
        // Eight I_cycle pulses: saturate at 7, sticky error
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(7'b1101111, 8'h00, 3'(i), 8'h4C, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(7'b1101111, 8'h00, 3'd7, 8'h4C, 1'b0, 2'd0, 1'b1));
        tbl.push_back(mk(7'b1100111, 8'h00, 3'd7, 8'h4C, 1'b0, 2'd0, 1'b1));
        tbl.push_back(mk(7'b1110111, 8'hEA, 3'd0, 8'hEA, 1'b1, 2'd0, 1'b1));
        tbl.push_back(mk(7'b1100111, 8'h00, 3'd0, 8'hEA, 1'b0, 2'd0, 1'b1));
        // Stall holds cycle/IR/sync
        tbl.push_back(mk(7'b1101111, 8'h00, 3'd1, 8'hEA, 1'b0, 2'd0, 1'b1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(7'b1011111, 8'hE9, 3'd1, 8'hEA, 1'b0, 2'd0, 1'b1));
        tbl.push_back(mk(7'b1110111, 8'hE9, 3'd0, 8'hE9, 1'b1, 2'd0, 1'b1));
        tbl.push_back(mk(7'b1010111, 8'h11, 3'd0, 8'hE9, 1'b1, 2'd0, 1'b1));
        tbl.push_back(mk(7'b1100111, 8'h11, 3'd0, 8'hE9, 1'b0, 2'd0, 1'b1));
        // Reset mid-instruction, asserted during a stall
        tbl.push_back(mk(7'b1101111, 8'h00, 3'd1, 8'hE9, 1'b0, 2'd0, 1'b1));
        tbl.push_back(mk(7'b1101111, 8'h00, 3'd2, 8'hE9, 1'b0, 2'd0, 1'b1));
        tbl.push_back(mk(7'b0011111, 8'h00, 3'd0, 8'h00, 1'b0, 2'd3, 1'b0));
        tbl.push_back(mk(7'b1010111, 8'h55, 3'd0, 8'h00, 1'b0, 2'd3, 1'b0));
        tbl.push_back(mk(7'b1110111, 8'h55, 3'd0, 8'h00, 1'b1, 2'd3, 1'b0));
        tbl.push_back(mk(7'b1110111, 8'h55, 3'd0, 8'h55, 1'b1, 2'd0, 1'b0));
        tbl.push_back(mk(7'b1100111, 8'h00, 3'd0, 8'h55, 1'b0, 2'd0, 1'b0));
        // Masked IRQ is ignored
        tbl.push_back(mk(7'b1100101, 8'h00, 3'd0, 8'h55, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(7'b1110101, 8'h38, 3'd0, 8'h38, 1'b1, 2'd0, 1'b0));
        tbl.push_back(mk(7'b1100111, 8'h00, 3'd0, 8'h38, 1'b0, 2'd0, 1'b0));

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // NMI edge mid-instruction with unmasked IRQ: NMI first, then IRQ
        run(mk(7'b1101000, 8'h00, 3'd1, 8'h38, 1'b0, 2'd0, 1'b0), "nmi_a");
        run(mk(7'b1101000, 8'h00, 3'd2, 8'h38, 1'b0, 2'd0, 1'b0), "nmi_b");
        run(mk(7'b1101000, 8'h00, 3'd3, 8'h38, 1'b0, 2'd0, 1'b0), "nmi_c");
        run(mk(7'b1110000, 8'h69, 3'd0, 8'h00, 1'b1, 2'd2, 1'b0), "nmi_inject");
        run(mk(7'b1100000, 8'h69, 3'd0, 8'h00, 1'b0, 2'd2, 1'b0), "nmi_hold");
        run(mk(7'b1110000, 8'h69, 3'd0, 8'h00, 1'b1, 2'd1, 1'b0), "irq_inject");
        run(mk(7'b1100010, 8'h69, 3'd0, 8'h00, 1'b0, 2'd1, 1'b0), "irq_release");
        run(mk(7'b1110010, 8'h69, 3'd0, 8'h69, 1'b1, 2'd0, 1'b0), "nmi_once");
        // IRQ withdrawn before the load edge: no injection
        run(mk(7'b1101000, 8'h00, 3'd1, 8'h69, 1'b0, 2'd0, 1'b0), "irq_pulse_a");
        run(mk(7'b1101010, 8'h00, 3'd2, 8'h69, 1'b0, 2'd0, 1'b0), "irq_pulse_b");
        run(mk(7'b1110010, 8'h6C, 3'd0, 8'h6C, 1'b1, 2'd0, 1'b0), "irq_withdrawn");
        // NMI edge arriving during a stall is still captured
        run(mk(7'b1100111, 8'h00, 3'd0, 8'h6C, 1'b0, 2'd0, 1'b0), "nmi_rise_a");
        run(mk(7'b1100111, 8'h00, 3'd0, 8'h6C, 1'b0, 2'd0, 1'b0), "nmi_rise_b");
        for (int i = 0; i < 3; i++)
            run(mk(7'b1010011, 8'h77, 3'd0, 8'h6C, 1'b0, 2'd0, 1'b0), $sformatf("nmi_stall%0d", i));
        run(mk(7'b1110011, 8'h77, 3'd0, 8'h00, 1'b1, 2'd2, 1'b0), "nmi_after_stall");
        run(mk(7'b1110011, 8'h77, 3'd0, 8'h77, 1'b1, 2'd0, 1'b0), "fetch_after_nmi");
        run(mk(7'b1100011, 8'h00, 3'd0, 8'h77, 1'b0, 2'd0, 1'b0), "final_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
